// File: rtl/tx_queue_pkg.sv
// Shared types and defaults for the tx_queue transmit word queue.
package tx_queue_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_DEPTH     = 4;
  localparam int DEFAULT_ADDR_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Occupancy counts 0..DEPTH, so it needs one bit more than a pointer.
  function automatic int level_bits(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/tx_queue_if.sv
// Producer/sender bundle for tx_queue; slave is the queue, master drives the queue.
interface tx_queue_if
  import tx_queue_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
);

  localparam int LVL_BITS = level_bits(ADDR_BITS);

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic [LVL_BITS-1:0]  level;
  logic                 send;
  logic [DATA_BITS-1:0] data_in;
  logic                 busy;
  logic                 ovf;

  modport master (
    output wr_en, wr_data, busy,
    input  full, level, send, data_in, ovf
  );

  modport slave (
    input  wr_en, wr_data, busy,
    output full, level, send, data_in, ovf
  );

endinterface

// File: rtl/tx_queue_mem.sv
// DEPTH x DATA_BITS word store: synchronous write, combinational read, no reset on contents.
module tx_queue_mem #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx_queue.sv
// Transmit word queue feeding the CDC sender one word at a time.
// Optional sticky overflow flag built only when TX_QUEUE_OVF_EN is defined.
module tx_queue
  import tx_queue_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  tx_queue_if.slave   bus
);

  localparam int LVL_BITS = level_bits(ADDR_BITS);
  localparam logic [LVL_BITS-1:0]  LVL_ZERO = {LVL_BITS{1'b0}};
  localparam logic [LVL_BITS-1:0]  LVL_FULL = LVL_BITS'(DEPTH);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_BITS-1:0]  level_q, level_d;
  logic                 full_q, full_d;
  logic                 send_q, send_d;
  logic [DATA_BITS-1:0] data_in_q, data_in_d;
  logic [DATA_BITS-1:0] head_s;
  logic                 wr_ok_s;
  logic                 pop_s;

  tx_queue_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok_s),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  // Pop decision uses the pre-edge level, so a word written to an empty queue pops a cycle later.
  always_comb begin
    wr_ok_s   = bus.wr_en & ~full_q;
    pop_s     = (state_q == IDLE) && (level_q != LVL_ZERO) && !bus.busy;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (pop_s) state_d = SEND;
        else       state_d = IDLE;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.busy) state_d = IDLE;
        else          state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (wr_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else         wr_ptr_d = wr_ptr_q;
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      data_in_d = head_s;
    end else begin
      rd_ptr_d  = rd_ptr_q;
      data_in_d = data_in_q;
    end
    level_d = level_q + LVL_BITS'(wr_ok_s) - LVL_BITS'(pop_s);
    full_d  = (level_d == LVL_FULL);
    send_d  = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= {ADDR_BITS{1'b0}};
      rd_ptr_q  <= {ADDR_BITS{1'b0}};
      level_q   <= LVL_ZERO;
      full_q    <= 1'b0;
      send_q    <= 1'b0;
      data_in_q <= {DATA_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      send_q    <= send_d;
      data_in_q <= data_in_d;
    end
  end

`ifdef TX_QUEUE_OVF_EN
  logic ovf_q, ovf_d;

  // Any write attempted while full is remembered until reset.
  always_comb begin
    ovf_d = ovf_q | (bus.wr_en & full_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.full    = full_q;
  assign bus.level   = level_q;
  assign bus.send    = send_q;
  assign bus.data_in = data_in_q;

endmodule

// File: tb/tb_tx_queue.sv
// Self-checking bench for tx_queue: directed phases plus random traffic against a queue-based model.
module tb_tx_queue;
  import tx_queue_pkg::*;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int AB    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_queue_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

  tx_queue #(.DATA_BITS(DB), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued words, one word in flight, sticky drop flag.
  logic [7:0] mdl_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] got[$];
  bit         m_sending;
  bit         m_waiting;
  bit         m_ovf;
  logic [7:0] m_data;
  bit         auto_snd;
  int         busy_cnt;
  int         hold_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sz;
    bit pop;
    bit acc;
    bit n_wait;
    if (rst === 1'b0) begin
      mdl_q.delete();
      m_sending = 1'b0;
      m_waiting = 1'b0;
      m_ovf     = 1'b0;
      m_data    = 8'h00;
    end else begin
      sz     = mdl_q.size();
      pop    = !m_sending && !m_waiting && (sz != 0) && !bus.busy;
      acc    = bus.wr_en && (sz < DEPTH);
      n_wait = m_sending || (m_waiting && !bus.busy);
      if (pop) m_data = mdl_q.pop_front();
      if (acc) begin
        mdl_q.push_back(bus.wr_data);
        acc_log.push_back(bus.wr_data);
      end
`ifdef TX_QUEUE_OVF_EN
      if (bus.wr_en && !acc) m_ovf = 1'b1;
`endif
      m_waiting = n_wait;
      m_sending = pop;
    end
  endtask

  task automatic step(input bit we, input logic [7:0] wd);
    bus.wr_en   = we;
    bus.wr_data = wd;
    if (auto_snd) begin
      bus.busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (m_sending) busy_cnt = hold_len;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("level",   32'(bus.level),   32'(mdl_q.size()));
    chk("full",    32'(bus.full),    32'(mdl_q.size() == DEPTH));
    chk("send",    32'(bus.send),    32'(m_sending));
    chk("data_in", 32'(bus.data_in), 32'(m_data));
    chk("ovf",     32'(bus.ovf),     32'(m_ovf));
    if (bus.send === 1'b1) got.push_back(bus.data_in);
  endtask

  initial begin
    int n;
    int nxt;
    int budget;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.busy    = 1'b0;
    auto_snd    = 1'b0;
    busy_cnt    = 0;
    hold_len    = 4;

    // Reset held with writes attempted
    repeat (3) step(1'b1, 8'hFF);
    chk("rst_level", 32'(bus.level),   32'd0);
    chk("rst_send",  32'(bus.send),    32'd0);
    chk("rst_data",  32'(bus.data_in), 32'd0);
    chk("rst_ovf",   32'(bus.ovf),     32'd0);
    rst = 1'b1;
    repeat (3) step(1'b0, 8'h00);
    chk("rst_nosend", 32'(got.size()), 32'd0);

    // Single word: send two cycles after the write
    step(1'b1, 8'hA5);
    chk("sw_early", 32'(bus.send), 32'd0);
    step(1'b0, 8'h00);
    chk("sw_send", 32'(bus.send), 32'd1);
    chk("sw_data", 32'(bus.data_in), 32'hA5);
    bus.busy = 1'b1;
    step(1'b0, 8'h00);
    chk("sw_once", 32'(bus.send), 32'd0);
    step(1'b0, 8'h00);
    bus.busy = 1'b0;
    repeat (2) step(1'b0, 8'h00);
    chk("sw_level", 32'(bus.level), 32'd0);
    chk("sw_count", 32'(got.size()), 32'd1);

    // Handshake gating: second word waits for busy to drop
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    chk("gate_send1", 32'(bus.send), 32'd1);
    chk("gate_data1", 32'(bus.data_in), 32'h11);
    bus.busy = 1'b1;
    n = got.size();
    repeat (10) step(1'b0, 8'h00);
    chk("gate_hold", 32'(got.size()), 32'(n));
    bus.busy = 1'b0;
    step(1'b0, 8'h00);
    chk("gate_send2", 32'(bus.send), 32'd1);
    chk("gate_data2", 32'(bus.data_in), 32'h22);
    bus.busy = 1'b1;
    repeat (2) step(1'b0, 8'h00);
    bus.busy = 1'b0;
    step(1'b0, 8'h00);

    // Full and overflow with the sender busy
    rst = 1'b0;
    bus.busy = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_flag",  32'(bus.full),  32'd1);
`ifdef TX_QUEUE_OVF_EN
    chk("full_ovf", 32'(bus.ovf), 32'd1);
`else
    chk("full_ovf", 32'(bus.ovf), 32'd0);
`endif
    got.delete();
    busy_cnt = 0;
    auto_snd = 1'b1;
    repeat (40) step(1'b0, 8'h00);
    chk("full_cnt", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("full_order", 32'(got[i]), 32'(i + 1));

    // Wrap: ten words through a four-entry queue
    busy_cnt = 0;
    rst = 1'b0;
    step(1'b0, 8'h00);
    rst = 1'b1;
    got.delete();
    nxt = 0;
    budget = 0;
    while ((nxt < 10 || got.size() < 10) && budget < 500) begin
      if (nxt < 10 && mdl_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        step(1'b1, 8'(nxt));
        nxt++;
      end else begin
        step(1'b0, 8'h00);
      end
      budget++;
    end
    chk("wrap_cnt", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i));

    // Random traffic with random sender hold times
    busy_cnt = 0;
    rst = 1'b0;
    step(1'b0, 8'h00);
    rst = 1'b1;
    got.delete();
    acc_log.delete();
    for (int i = 0; i < 300; i++) begin
      hold_len = $urandom_range(1, 6);
      step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    budget = 0;
    while (got.size() < acc_log.size() && budget < 200) begin
      step(1'b0, 8'h00);
      budget++;
    end
    chk("rand_cnt", 32'(got.size()), 32'(acc_log.size()));
    for (int i = 0; i < got.size() && i < acc_log.size(); i++) chk("rand_order", 32'(got[i]), 32'(acc_log[i]));

    // Reset mid-operation: three words queued, one in flight
    auto_snd = 1'b0;
    hold_len = 4;
    bus.busy = 1'b0;
    rst = 1'b0;
    step(1'b0, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i));
    chk("mid_level", 32'(bus.level), 32'd3);
    rst = 1'b0;
    step(1'b0, 8'h00);
    rst = 1'b1;
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    n = got.size();
    repeat (10) step(1'b0, 8'h00);
    chk("mid_nosend", 32'(got.size()), 32'(n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
